// File: rtl/trace_pkg.sv
// Shared types and defaults for the signal trace capture block.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
//   TS_W_DEF/C_W_DEF/DEPTH_DEF : default geometry
//   REC_W                      : record width {ts, a, b, c} at default geometry
//   trace_rec_t                : record layout at default geometry
//   trace_state_t              : capture FSM states
package trace_pkg;

  localparam int TS_W_DEF  = 16;
  localparam int C_W_DEF   = 8;
  localparam int DEPTH_DEF = 16;
  localparam int REC_W     = TS_W_DEF + C_W_DEF + 2;

  typedef struct packed {
    logic [TS_W_DEF-1:0] ts;
    logic                a;
    logic                b;
    logic [C_W_DEF-1:0]  c;
  } trace_rec_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BASE = 2'd1,
    ST_RUN  = 2'd2
  } trace_state_t;

  // Saturating 8-bit increment for the drop counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/signal_trace_capture_if.sv
// Record read-out bus from the trace capture block to its reader.
// Latency: n/a (wires only).
// Backpressure: reader holds rd_ready low to stall; record pops on rd_valid && rd_ready.
//   rd_valid : head record available (master -> slave)
//   rd_ready : reader accepts head record (slave -> master)
//   rd_data  : head record {ts, a, b, c} (master -> slave)
interface signal_trace_capture_if
  import trace_pkg::*;
#(
  parameter int W = REC_W
) ();

  logic         rd_valid;
  logic         rd_ready;
  logic [W-1:0] rd_data;

  modport master (output rd_valid, output rd_data, input rd_ready);
  modport slave  (input rd_valid, input rd_data, output rd_ready);

endinterface

// File: rtl/trace_fifo.sv
// First-word-fall-through FIFO holding trace records.
// Latency: a word pushed at edge N is on dout with empty=0 right after edge N.
// Backpressure: push ignored when full unless a pop happens the same cycle; pop ignored when empty.
//   push/din/full  : write side
//   pop/dout/empty : read side (dout = head word, meaningful only when !empty)
//   level          : current occupancy
module trace_fifo #(
  parameter int  DEPTH = 16,
  parameter int  W     = 26,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  din,
  output logic          full,
  input  logic          pop,
  output logic          empty,
  output logic [W-1:0]  dout,
  output logic [LW-1:0] level
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  assign full  = (cnt == LW'(DEPTH));
  assign empty = (cnt == '0);
  assign level = cnt;
  assign dout  = mem[rd_ptr];

  // No bypass: a pop needs a word already stored. A push into a full FIFO
  // is taken only when the head is leaving this same cycle; the write then
  // lands in the slot being vacated, which is read before the edge.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (do_push && !do_pop) begin
        cnt <= cnt + LW'(1);
      end else if (do_pop && !do_push) begin
        cnt <= cnt - LW'(1);
      end
    end
  end

endmodule

// File: rtl/signal_trace_capture.sv
// Samples a, b, c every clock and queues a timestamped record on every change while armed.
// Latency: change sampled at edge N is readable after edge N (after edge N+2 with TRACE_INPUT_SYNC_EN).
// Backpressure: reader stalls via rd_ready; records arriving while the FIFO is full are dropped and counted.
//   clk, rst_n     : clock, asynchronous active-low reset
//   arm            : level, high = capture running (rising edge restarts ts and drop accounting)
//   a, b, c        : monitored inputs
//   rd             : record read-out bus (master side)
//   level          : FIFO occupancy
//   overflow       : sticky, a record was dropped since arm
//   drop_cnt       : dropped records, saturating at 255
//   busy           : FSM not idle
// Build option TRACE_INPUT_SYNC_EN: pass a, b, c through 2-flop synchronizers before comparison.
module signal_trace_capture
  import trace_pkg::*;
#(
  parameter int  DEPTH = DEPTH_DEF,
  parameter int  TS_W  = TS_W_DEF,
  parameter int  C_W   = C_W_DEF,
  localparam int LW    = $clog2(DEPTH) + 1,
  localparam int SW    = C_W + 2,
  localparam int RW    = TS_W + SW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   arm,
  input  logic                   a,
  input  logic                   b,
  input  logic [C_W-1:0]         c,
  signal_trace_capture_if.master rd,
  output logic [LW-1:0]          level,
  output logic                   overflow,
  output logic [7:0]             drop_cnt,
  output logic                   busy
);

  trace_state_t    state;
  logic            arm_q;
  logic [TS_W-1:0] ts;
  logic [SW-1:0]   smp;
  logic [SW-1:0]   prev;
  logic            push_req;
  logic            pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [RW-1:0]   fifo_dout;
  logic [RW-1:0]   last_dat;

`ifdef TRACE_INPUT_SYNC_EN
  logic [SW-1:0] sync1;
  logic [SW-1:0] sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {a, b, c};
      sync2 <= sync1;
    end
  end

  assign smp = sync2;
`else
  assign smp = {a, b, c};
`endif

  // The baseline goes in even if arm drops during BASE; in RUN only while armed.
  assign push_req = (state == ST_BASE) ||
                    ((state == ST_RUN) && arm && (smp != prev));

  assign pop         = !fifo_empty && rd.rd_ready;
  assign rd.rd_valid = !fifo_empty;
  // Keep showing the last popped record while empty rather than a stale slot.
  assign rd.rd_data  = fifo_empty ? last_dat : fifo_dout;

  trace_fifo #(
    .DEPTH (DEPTH),
    .W     (RW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_req),
    .din   ({ts, smp}),
    .full  (fifo_full),
    .pop   (pop),
    .empty (fifo_empty),
    .dout  (fifo_dout),
    .level (level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_dat <= '0;
    end else if (pop) begin
      last_dat <= fifo_dout;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      arm_q    <= 1'b0;
      ts       <= '0;
      prev     <= '0;
      overflow <= 1'b0;
      drop_cnt <= 8'd0;
    end else begin
      arm_q <= arm;

      // Pushes only happen outside IDLE, so this never collides with the
      // clear on arm rise below.
      if (push_req && fifo_full && !pop) begin
        overflow <= 1'b1;
        drop_cnt <= sat_inc8(drop_cnt);
      end

      case (state)
        ST_IDLE: begin
          if (arm && !arm_q) begin
            state    <= ST_BASE;
            busy     <= 1'b1;
            ts       <= '0;
            overflow <= 1'b0;
            drop_cnt <= 8'd0;
          end
        end
        ST_BASE: begin
          prev <= smp;
          if (arm) begin
            state <= ST_RUN;
            ts    <= ts + TS_W'(1);
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (!arm) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            ts   <= ts + TS_W'(1);
            prev <= smp;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_signal_trace_capture.sv
// Directed bench for signal_trace_capture: default geometry instance plus a TS_W=4 instance for wrap.
// Latency: n/a.
// Backpressure: rd_ready driven directly by the stimulus sequence.
module tb_signal_trace_capture;
  import trace_pkg::*;

`ifdef TRACE_INPUT_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif

  logic       clk;
  logic       rst_n;
  logic       arm;
  logic       a;
  logic       b;
  logic [7:0] c;
  logic [4:0] level;
  logic       overflow;
  logic [7:0] drop_cnt;
  logic       busy;

  logic       arm2;
  logic       a2;
  logic       b2;
  logic [7:0] c2;
  logic [4:0] level2;
  logic       overflow2;
  logic [7:0] drop_cnt2;
  logic       busy2;

  int tests;
  int fails;

  signal_trace_capture_if #(.W(26)) rd_if ();
  signal_trace_capture_if #(.W(14)) rd_if2 ();

  signal_trace_capture dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .arm      (arm),
    .a        (a),
    .b        (b),
    .c        (c),
    .rd       (rd_if),
    .level    (level),
    .overflow (overflow),
    .drop_cnt (drop_cnt),
    .busy     (busy)
  );

  signal_trace_capture #(.DEPTH(16), .TS_W(4), .C_W(8)) dut2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .arm      (arm2),
    .a        (a2),
    .b        (b2),
    .c        (c2),
    .rd       (rd_if2),
    .level    (level2),
    .overflow (overflow2),
    .drop_cnt (drop_cnt2),
    .busy     (busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [25:0] rec(input int t, input logic ra, input logic rb, input int rc);
    trace_rec_t r;
    r.ts = 16'(t);
    r.a  = ra;
    r.b  = rb;
    r.c  = 8'(rc);
    return r;
  endfunction

  logic [25:0] exp2 [5];

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    arm = 1'b0; a = 1'b1; b = 1'b0; c = 8'd1;
    rd_if.rd_ready = 1'b0;
    arm2 = 1'b0; a2 = 1'b0; b2 = 1'b0; c2 = 8'd0;
    rd_if2.rd_ready = 1'b0;

    // Reset state
    repeat (2) tick();
    chk("rst_rd_valid", rd_if.rd_valid, 0);
    chk("rst_rd_data", rd_if.rd_data, 0);
    chk("rst_level", level, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("idle_busy", busy, 0);

    // 1: arm rise -> baseline record
    arm = 1'b1;
    tick();
    chk("t1_busy_base", busy, 1);
    chk("t1_level_base", level, 0);
    tick();
    chk("t1_level", level, 1);
    chk("t1_rd_valid", rd_if.rd_valid, 1);
    chk("t1_baseline", rd_if.rd_data, rec(0, 1, 0, 1));

    // 2: changes at ts=2,3,4 and simultaneous a/c change at ts=5
    tick();
    b = 1'b1; tick();
    b = 1'b0; tick();
    c = 8'd2; tick();
    a = 1'b0; c = 8'd3; tick();
    repeat (SL) tick();
    chk("t2_level", level, 5);
    exp2[0] = rec(0, 1, 0, 1);
    exp2[1] = rec(2 + SL, 1, 1, 1);
    exp2[2] = rec(3 + SL, 1, 0, 1);
    exp2[3] = rec(4 + SL, 1, 0, 2);
    exp2[4] = rec(5 + SL, 0, 0, 3);
    rd_if.rd_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t2_rec%0d", i), rd_if.rd_data, exp2[i]);
      tick();
    end
    rd_if.rd_ready = 1'b0;
    chk("t2_empty_level", level, 0);
    chk("t2_empty_valid", rd_if.rd_valid, 0);
    chk("t2_hold_data", rd_if.rd_data, exp2[4]);

    // 3: overflow with 20 toggles into a 16-deep FIFO
    arm = 1'b0; tick();
    arm = 1'b1; tick();
    tick();
    chk("t3_baseline_level", level, 1);
    for (int i = 0; i < 20; i++) begin
      b = ~b;
      tick();
    end
    repeat (SL) tick();
    chk("t3_level_full", level, 16);
    chk("t3_overflow", overflow, 1);
    chk("t3_drop_cnt", drop_cnt, 5);
    chk("t3_head_baseline", rd_if.rd_data, rec(0, 0, 0, 3));
    rd_if.rd_ready = 1'b1;
    b = ~b;
    tick();
    rd_if.rd_ready = 1'b0;
    repeat (SL) tick();
    chk("t3_poppush_level", level, 16);
    chk("t3_poppush_drop", drop_cnt, 5);
    chk("t3_head_r1", rd_if.rd_data, rec(1 + SL, 0, 1, 3));
    b = ~b;
    tick();
    repeat (SL) tick();
    chk("t3_drop_again", drop_cnt, 6);
    chk("t3_level_still", level, 16);

    // 5: arm low, drain some, re-arm; old records stay ahead of new baseline
    arm = 1'b0; tick();
    chk("t5_busy_idle", busy, 0);
    chk("t5_level_kept", level, 16);
    rd_if.rd_ready = 1'b1;
    repeat (3) tick();
    rd_if.rd_ready = 1'b0;
    chk("t5_level_drained", level, 13);
    chk("t5_head_r4", rd_if.rd_data, rec(4 + SL, 0, 0, 3));
    arm = 1'b1; tick();
    chk("t5_overflow_clr", overflow, 0);
    chk("t5_drop_clr", drop_cnt, 0);
    chk("t5_busy_rearm", busy, 1);
    tick();
    chk("t5_level_rearm", level, 14);
    rd_if.rd_ready = 1'b1;
    repeat (13) tick();
    chk("t5_new_baseline", rd_if.rd_data, rec(0, 0, 0, 3));
    chk("t5_level_one", level, 1);
    rd_if.rd_ready = 1'b0;
    tick();
    chk("t5_level_before_rst", level, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", rd_if.rd_valid, 0);
    chk("t5_rst_level", level, 0);
    chk("t5_rst_busy", busy, 0);
    tick();
    arm = 1'b0;
    rst_n = 1'b1;
    repeat (SL + 2) tick();

    // 6: change-to-push latency
    arm = 1'b1; tick();
    tick();
    chk("t6_baseline_level", level, 1);
    b = 1'b1;
    for (int i = 0; i <= SL; i++) begin
      tick();
      chk($sformatf("t6_level_c%0d", i), level, (i == SL) ? 2 : 1);
    end

    // 4: timestamp wrap with TS_W=4
    arm2 = 1'b1; tick();
    tick();
    chk("t4_baseline_level", level2, 1);
    chk("t4_baseline", rd_if2.rd_data, 14'd0);
    repeat (16) tick();
    a2 = 1'b1;
    tick();
    repeat (SL) tick();
    chk("t4_level", level2, 2);
    rd_if2.rd_ready = 1'b1;
    tick();
    rd_if2.rd_ready = 1'b0;
    chk("t4_wrap_rec", rd_if2.rd_data, {4'(1 + SL), 1'b1, 1'b0, 8'h00});
    chk("t4_overflow", overflow2, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
